seq_blinker: RTL

Playback stage for the Simon-style game: when the game controller enters its blink state, this block walks the stored colour sequence from index 0 to `level-1` and shows each entry on a one-hot LED bus, with a timed off-gap after each one. It sits directly downstream of the game controller. It consumes `on_blinker` and the level value and reads the sequence memory, then returns `blinker_done` so the controller can move to player input.

---
 rtl/seq_blinker.sv | 131 +++++++++++++
 1 files changed

// File: rtl/seq_blinker.sv
// Plays the stored colour sequence on a one-hot LED bus, one FETCH + ON + OFF slot per element.
// LED follows the element state one edge later; no backpressure, dropping on_blinker aborts on the next edge.
module seq_blinker #(
    parameter int ON_CYCLES  = 25_000_000,
    parameter int OFF_CYCLES = 12_500_000,
    parameter int MAX_LEVEL  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       on_blinker,
    input  logic [3:0] level,
    output logic [3:0] mem_addr,
    input  logic [1:0] mem_data,
    output logic [3:0] led,
    output logic       blinker_done
);

    localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ON,
        S_OFF,
        S_DONE
    } state_t;

    state_t        state, state_n;
    logic [3:0]    lvl, lvl_n;
    logic [3:0]    idx, idx_n;
    logic [1:0]    col, col_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    addr_n;
    logic [3:0]    led_n;
    logic          done_n;
    logic [3:0]    lvl_clamp;
    logic [3:0]    idx_inc;

    assign lvl_clamp = (32'(level) > MAX_LEVEL) ? 4'(MAX_LEVEL) : level;
    assign idx_inc   = idx + 4'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            lvl          <= '0;
            idx          <= '0;
            col          <= '0;
            cnt          <= '0;
            mem_addr     <= '0;
            led          <= '0;
            blinker_done <= 1'b0;
        end else begin
            state        <= state_n;
            lvl          <= lvl_n;
            idx          <= idx_n;
            col          <= col_n;
            cnt          <= cnt_n;
            mem_addr     <= addr_n;
            led          <= led_n;
            blinker_done <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        lvl_n   = lvl;
        idx_n   = idx;
        col_n   = col;
        cnt_n   = cnt;
        addr_n  = mem_addr;
        led_n   = 4'b0000;
        done_n  = 1'b0;

        case (state)
            S_IDLE: begin
                if (on_blinker) begin
                    lvl_n   = lvl_clamp;
                    idx_n   = '0;
                    addr_n  = '0;
                    state_n = (lvl_clamp == 4'd0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                col_n   = mem_data;
                cnt_n   = '0;
                state_n = S_ON;
            end
            S_ON: begin
                // The lit value is registered from the ON state itself, so the final
                // ON cycle still lights the LED for one more cycle after leaving ON.
                led_n = 4'b0001 << col;
                cnt_n = cnt + 1'b1;
                if (cnt == CW'(ON_CYCLES - 1)) begin
                    cnt_n   = '0;
                    state_n = S_OFF;
                end
            end
            S_OFF: begin
                cnt_n = cnt + 1'b1;
                if (cnt == CW'(OFF_CYCLES - 1)) begin
                    cnt_n = '0;
                    if (idx_inc == lvl) begin
                        state_n = S_DONE;
                        done_n  = 1'b1;
                    end else begin
                        idx_n   = idx_inc;
                        addr_n  = idx_inc;
                        state_n = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                done_n = 1'b1;
                if (!on_blinker) begin
                    done_n  = 1'b0;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // A dropped request mid-playback discards everything and goes dark.
        if (!on_blinker && (state == S_FETCH || state == S_ON || state == S_OFF)) begin
            state_n = S_IDLE;
            led_n   = 4'b0000;
            done_n  = 1'b0;
        end
    end

endmodule
